// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) for the
// multiplier product magnitude, with sign capture and a start/busy/done handshake.
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_neg,
  input  logic [WIDTH-1:0]      product,
  output logic                  busy,
  output logic                  done,
  output logic                  sign_out,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               sgn_q,    sgn_d;
  logic [BCD_W-1:0]   bcd_q,    bcd_d;
  logic               sign_q,   sign_d;
  logic               done_q,   done_d;
  logic [BCD_W-1:0]   bcd_adj;

  // Digits are <= 9 before adjust, so each 4-bit add can never carry out.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj = add3_adjust(bcd_sr_q);

  always_comb begin
    state_d  = state_q;
    bin_sr_d = bin_sr_q;
    bcd_sr_d = bcd_sr_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    bcd_d    = bcd_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_sr_d = product;
          bcd_sr_d = '0;
          cnt_d    = '0;
          sgn_d    = is_neg & (product != '0);
          state_d  = S_CONVERT;
        end
      end
      S_CONVERT: begin
        bcd_sr_d = {bcd_adj[BCD_W-2:0], bin_sr_q[WIDTH-1]};
        bin_sr_d = {bin_sr_q[WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = bcd_sr_q;
        sign_d  = sgn_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bin_sr_q <= '0;
      bcd_sr_q <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      bcd_q    <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      bcd_sr_q <= bcd_sr_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      bcd_q    <= bcd_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign sign_out = sign_q;
  assign bcd      = bcd_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomized self-checking bench for product_bcd_converter against a decimal
// digit model, plus directed handshake, sign and reset-abort scenarios.
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_neg;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic        sign_out;
  logic [19:0] bcd;

  int checks = 0;
  int errors = 0;

  product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_neg   (is_neg),
    .product  (product),
    .busy     (busy),
    .done     (done),
    .sign_out (sign_out),
    .bcd      (bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Decimal model: peel base-10 digits off the integer value.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Starts a conversion at the next edge (edge 0) and follows it until done.
  // With interfere set, extra starts of 9999 are pulsed on edges 3 and 17.
  task automatic run(input logic [15:0] p, input logic neg, input bit interfere);
    logic [19:0] prev_bcd;
    logic        prev_sign;
    int          n;
    bit          seen, busy_bad, hold_bad;
    prev_bcd  = bcd;
    prev_sign = sign_out;
    start = 1'b1; product = p; is_neg = neg;
    @(posedge clk); #1;
    start = 1'b0; product = 16'($urandom); is_neg = 1'($urandom);
    chk("done_width", {31'd0, done}, 32'd0);
    chk("busy_start", {31'd0, busy}, 32'd1);
    n = 0; seen = 0; busy_bad = 0; hold_bad = 0;
    while (!seen && n < 40) begin
      if (interfere && (n == 2 || n == 16)) begin
        start = 1'b1; product = 16'd9999; is_neg = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done) seen = 1;
      else begin
        if (!busy && n < 17) busy_bad = 1;
        if (bcd !== prev_bcd || sign_out !== prev_sign) hold_bad = 1;
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", n, 32'd17);
    chk("busy_span", {31'd0, busy_bad}, 32'd0);
    chk("hold_prev", {31'd0, hold_bad}, 32'd0);
    chk("bcd", {12'd0, bcd}, {12'd0, ref_bcd(int'(p))});
    chk("sign", {31'd0, sign_out}, {31'd0, neg && (p != 16'd0)});
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit          bad;
    logic [15:0] p;
    rst = 1'b1; start = 1'b0; is_neg = 1'b0; product = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sign", {31'd0, sign_out}, 32'd0);
    chk("rst_bcd", {12'd0, bcd}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run(16'h3F01, 1'b0, 1'b0);
    run(16'h4000, 1'b0, 1'b0);
    run(16'd300,  1'b1, 1'b0);
    run(16'd0,    1'b1, 1'b0);
    run(16'hFFFF, 1'b0, 1'b0);
    run(16'd1234, 1'b0, 1'b1);
    run(16'd9999, 1'b0, 1'b0);

    // Abort mid-conversion: previous result is nonzero and negative.
    run(16'd300, 1'b1, 1'b0);
    start = 1'b1; product = 16'd555; is_neg = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_bcd", {12'd0, bcd}, 32'd0);
    chk("abort_sign", {31'd0, sign_out}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done || busy || bcd !== 20'd0) bad = 1;
    end
    chk("abort_quiet", {31'd0, bad}, 32'd0);
    run(16'd42, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      case ($urandom_range(0, 9))
        0:       p = 16'd0;
        1:       p = 16'hFFFF;
        2:       p = 16'($urandom_range(0, 99));
        default: p = 16'($urandom);
      endcase
      run(p, 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
